iobuf_offset_cal: RTL and testbench



---
 rtl/iobuf_offset_cal.sv | 190 +++++++++++++++++++
 tb/tb_iobuf_offset_cal.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/iobuf_offset_cal.sv
// rtl/iobuf_offset_cal.sv - IOBUFE3 input-buffer offset calibration sequencer
//
// Sweeps the pad trim code from -7 to +7 and records the first code at which
// the (synchronized) buffer output reads 1 by majority. Optional feature
// macro: IOBUF_CAL_ABORT_EN adds an abort input that cancels a running sweep.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       calibration request, sampled only in IDLE
//   abort       (IOBUF_CAL_ABORT_EN only) cancel a running sweep
//   buf_o       IOBUFE3 O output, asynchronous
//   osc, osc_en IOBUFE3 OSC trim code (bit 3 = sign, 1 = positive) and enable
//   busy        sweep in progress
//   done        one-cycle completion pulse
//   cal_err     no in-range transition found
//   code_out    calibrated code, osc encoding
//   code_valid  code_out holds a completed result
module iobuf_offset_cal #(
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef IOBUF_CAL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       buf_o,
    output logic [3:0] osc,
    output logic       osc_en,
    output logic       busy,
    output logic       done,
    output logic       cal_err,
    output logic [3:0] code_out,
    output logic       code_valid
);

    localparam int SW = $clog2(SAMPLES);
    localparam int OW = SW + 1;

    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES - 1);
    localparam logic [OW:0]   SAMPLES_W   = (OW + 1)'(SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EVAL,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    step;
    logic [7:0]    settle_cnt;
    logic [SW-1:0] sample_cnt;
    logic [OW-1:0] ones;
    logic          sync1;
    logic          sync2;
    logic [3:0]    res_code;
    logic          res_err;
    logic          prev_valid;
    logic          abort_req;
    logic          hit;

`ifdef IOBUF_CAL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Majority with ties counted as a hit: 2*ones >= SAMPLES.
    assign hit = ({1'b0, ones, 1'b0} >= {1'b0, SAMPLES_W});

    // Step s maps to value s-7; zero is encoded as positive (4'b1000).
    function automatic logic [3:0] enc(input logic [3:0] s);
        logic [3:0] d;
        if (s < 4'd7) begin
            d = 4'd7 - s;
            return {1'b0, d[2:0]};
        end else begin
            d = s - 4'd7;
            return {1'b1, d[2:0]};
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step       <= 4'd0;
            settle_cnt <= 8'd0;
            sample_cnt <= '0;
            ones       <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            res_code   <= 4'b1000;
            res_err    <= 1'b0;
            prev_valid <= 1'b0;
            osc        <= 4'b1000;
            osc_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cal_err    <= 1'b0;
            code_out   <= 4'b1000;
            code_valid <= 1'b0;
        end else begin
            sync1 <= buf_o;
            sync2 <= sync1;
            done  <= 1'b0;
            if (abort_req && (state == SETTLE || state == SAMPLE || state == EVAL)) begin
                // code_out is only written in DONE, so it still holds the
                // pre-start result; only code_valid needs restoring.
                state      <= IDLE;
                osc_en     <= 1'b0;
                busy       <= 1'b0;
                osc        <= code_out;
                code_valid <= prev_valid;
                cal_err    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        osc    <= code_out;
                        osc_en <= 1'b0;
                        if (start) begin
                            step       <= 4'd0;
                            osc        <= enc(4'd0);
                            osc_en     <= 1'b1;
                            busy       <= 1'b1;
                            cal_err    <= 1'b0;
                            prev_valid <= code_valid;
                            code_valid <= 1'b0;
                            settle_cnt <= 8'd0;
                            ones       <= '0;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // Also covers the two-flop synchronizer latency.
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= 8'd0;
                            sample_cnt <= '0;
                            state      <= SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                    SAMPLE: begin
                        ones <= ones + OW'(sync2);
                        if (sample_cnt == SAMPLE_LAST) begin
                            state <= EVAL;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                    EVAL: begin
                        if (hit) begin
                            // A hit at the first code means the offset is
                            // beyond the negative trim range.
                            res_err  <= (step == 4'd0);
                            res_code <= (step == 4'd0) ? 4'b0111 : osc;
                            state    <= DONE;
                        end else if (step == 4'd14) begin
                            res_err  <= 1'b1;
                            res_code <= 4'b1111;
                            state    <= DONE;
                        end else begin
                            step       <= step + 4'd1;
                            osc        <= enc(step + 4'd1);
                            ones       <= '0;
                            settle_cnt <= 8'd0;
                            state      <= SETTLE;
                        end
                    end
                    DONE: begin
                        code_out   <= res_code;
                        code_valid <= 1'b1;
                        cal_err    <= res_err;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        osc_en     <= 1'b0;
                        osc        <= res_code;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iobuf_offset_cal.sv
// tb/tb_iobuf_offset_cal.sv - directed bench for iobuf_offset_cal
module tb_iobuf_offset_cal;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
`ifdef IOBUF_CAL_ABORT_EN
    logic       abort;
`endif
    logic       buf_o;
    logic [3:0] osc;
    logic       osc_en;
    logic       busy;
    logic       done;
    logic       cal_err;
    logic [3:0] code_out;
    logic       code_valid;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   off = 0;
    logic tog = 1'b0;

    iobuf_offset_cal dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef IOBUF_CAL_ABORT_EN
        .abort     (abort),
`endif
        .buf_o     (buf_o),
        .osc       (osc),
        .osc_en    (osc_en),
        .busy      (busy),
        .done      (done),
        .cal_err   (cal_err),
        .code_out  (code_out),
        .code_valid(code_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad comparator model: off + osc_int, osc_int = +/-5 * magnitude.
    always @(negedge clk) begin
        int oi;
        int sum;
        tog = ~tog;
        oi  = 5 * int'(osc[2:0]);
        if (!osc[3]) oi = -oi;
        sum = off + oi;
        if (sum > 0)       buf_o = 1'b1;
        else if (sum == 0) buf_o = tog;
        else               buf_o = 1'b0;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a calibration and waits for done; optional extra start pulse at
    // loop index pulse_at while the sweep is busy.
    task automatic run_cal(input int o, input int pulse_at, output int lat);
        off = o;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk) start = 1'b0;
        check("osc_first", int'(osc), 7);
        check("busy_first", int'(busy), 1);
        check("osc_en_first", int'(osc_en), 1);
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                lat = cyc - c0;
                break;
            end
            start = (i == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input int exp_code, input int exp_err);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_code"}, int'(code_out), exp_code);
        check({tag, "_err"}, int'(cal_err), exp_err);
        check({tag, "_valid"}, int'(code_valid), 1);
        check({tag, "_osc"}, int'(osc), exp_code);
        check({tag, "_osc_en"}, int'(osc_en), 0);
        check({tag, "_busy"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_osc_idle"}, int'(osc), exp_code);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        buf_o = 1'b0;
`ifdef IOBUF_CAL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_osc", int'(osc), 8);
        check("rst_code", int'(code_out), 8);
        check("rst_osc_en", int'(osc_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(cal_err), 0);
        check("rst_valid", int'(code_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        run_cal(-12, -1, lat);
        check_result("off_m12", lat, 276, 4'b1011, 0);

        run_cal(-15, -1, lat);
        check_result("tie", lat, 276, 4'b1011, 0);

        run_cal(40, -1, lat);
        check_result("off_p40", lat, 26, 4'b0111, 1);

        run_cal(-40, -1, lat);
        check_result("off_m40", lat, 376, 4'b1111, 1);

        // Reset during SAMPLE of step 5 (cycles 134..149 after start).
        off = -12;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk) start = 1'b0;
        repeat (139) @(negedge clk);
        check("mid_busy", int'(busy), 1);
        check("mid_osc", int'(osc), 4'b0010);
        rst = 1'b1;
        #1;
        check("arst_osc", int'(osc), 8);
        check("arst_code", int'(code_out), 8);
        check("arst_osc_en", int'(osc_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(cal_err), 0);
        check("arst_valid", int'(code_valid), 0);
        @(negedge clk) rst = 1'b0;
        count_done(300, cnt);
        check("arst_no_done", cnt, 0);

        run_cal(-12, -1, lat);
        check_result("post_rst", lat, 276, 4'b1011, 0);

        // Extra start while busy must not disturb the sweep.
        run_cal(-12, 50, lat);
        check_result("start_busy", lat, 276, 4'b1011, 0);

`ifdef IOBUF_CAL_ABORT_EN
        // Step 3 occupies cycles 76..100 after start.
        off = -12;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk) start = 1'b0;
        repeat (80) @(negedge clk);
        check("abort_pre_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_osc_en", int'(osc_en), 0);
        check("abort_osc", int'(osc), 4'b1011);
        check("abort_code", int'(code_out), 4'b1011);
        check("abort_valid", int'(code_valid), 1);
        check("abort_err", int'(cal_err), 0);
        check("abort_done", int'(done), 0);
        count_done(400, cnt);
        check("abort_no_done", cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
